// File: rtl/procesador_fifo_pkg.sv
// Shared constants for the MM-to-ST host FIFO: register map, status bit layout,
// overflow counter width.
package procesador_fifo_pkg;
  localparam logic ADDR_DATA    = 1'b0;
  localparam logic ADDR_STATUS  = 1'b1;
  localparam int   STAT_FULL    = 31;
  localparam int   STAT_EMPTY   = 30;
  localparam int   STAT_OVF_LSB = 16;
  localparam int   OVF_W        = 14;
endpackage

// File: rtl/procesador_fifo_mm_to_st_ram.sv
// Simple dual-port buffer RAM; the read port registers straight into the
// stream output data register.
module procesador_fifo_mm_to_st_ram #(
  parameter int DATA_W = 32,
  parameter int DEPTH  = 128,
  parameter int ADDR_W = 7
) (
  input  logic              i_clk,
  input  logic              i_rst_n,
  input  logic              i_wr_en,
  input  logic [ADDR_W-1:0] i_wr_addr,
  input  logic [DATA_W-1:0] i_wr_data,
  input  logic              i_rd_en,
  input  logic [ADDR_W-1:0] i_rd_addr,
  output logic [DATA_W-1:0] o_rd_data
);
  logic [DATA_W-1:0] r_mem [DEPTH];

  always_ff @(posedge i_clk) begin
    if (i_wr_en) r_mem[i_wr_addr] <= i_wr_data;
  end

  always_ff @(posedge i_clk or negedge i_rst_n) begin
    if (!i_rst_n)     o_rd_data <= '0;
    else if (i_rd_en) o_rd_data <= r_mem[i_rd_addr];
  end
endmodule

// File: rtl/procesador_fifo_mm_to_st.sv
// Avalon-MM write slave feeding an Avalon-ST source through a circular buffer.
// Optional overflow counter: PROCESADOR_FIFO_OVF_CNT_EN.
module procesador_fifo_mm_to_st
  import procesador_fifo_pkg::*;
#(
  parameter int DATA_W = 32,
  parameter int DEPTH  = 128,
  parameter int ADDR_W = 7
) (
  input  logic              wrclock,
  input  logic              reset_n,
  input  logic              avalonmm_write_slave_address,
  input  logic              avalonmm_write_slave_write,
  input  logic [DATA_W-1:0] avalonmm_write_slave_writedata,
  input  logic              avalonmm_write_slave_read,
  output logic [31:0]       avalonmm_write_slave_readdata,
  output logic [DATA_W-1:0] avalonst_source_data,
  output logic              avalonst_source_valid,
  input  logic              avalonst_source_ready,
  output logic              full,
  output logic              empty
);
  logic [ADDR_W-1:0] r_wr_ptr, r_rd_ptr;
  logic [ADDR_W:0]   r_count;
  logic              r_valid;
  logic              w_push, w_load;
  logic [OVF_W-1:0]  w_ovf;
  logic [31:0]       w_status;

  assign full  = (r_count == (ADDR_W+1)'(DEPTH));
  assign empty = (r_count == '0) && !r_valid;

  assign w_push = avalonmm_write_slave_write && (avalonmm_write_slave_address == ADDR_DATA) && !full;
  // Refill the output register whenever it is free or being consumed this cycle.
  assign w_load = (!r_valid || avalonst_source_ready) && (r_count != '0);

  always_ff @(posedge wrclock or negedge reset_n) begin
    if (!reset_n) begin
      r_wr_ptr <= '0;
      r_rd_ptr <= '0;
      r_count  <= '0;
      r_valid  <= 1'b0;
    end else begin
      if (w_push) r_wr_ptr <= r_wr_ptr + 1'b1;
      if (w_load) r_rd_ptr <= r_rd_ptr + 1'b1;
      case ({w_push, w_load})
        2'b10:   r_count <= r_count + 1'b1;
        2'b01:   r_count <= r_count - 1'b1;
        default: r_count <= r_count;
      endcase
      if (w_load)                     r_valid <= 1'b1;
      else if (avalonst_source_ready) r_valid <= 1'b0;
    end
  end

  assign avalonst_source_valid = r_valid;

  procesador_fifo_mm_to_st_ram #(
    .DATA_W (DATA_W),
    .DEPTH  (DEPTH),
    .ADDR_W (ADDR_W)
  ) u_ram (
    .i_clk     (wrclock),
    .i_rst_n   (reset_n),
    .i_wr_en   (w_push),
    .i_wr_addr (r_wr_ptr),
    .i_wr_data (avalonmm_write_slave_writedata),
    .i_rd_en   (w_load),
    .i_rd_addr (r_rd_ptr),
    .o_rd_data (avalonst_source_data)
  );

`ifdef PROCESADOR_FIFO_OVF_CNT_EN
  logic             w_drop, w_ovf_clr;
  logic [OVF_W-1:0] r_ovf;

  assign w_drop    = avalonmm_write_slave_write && (avalonmm_write_slave_address == ADDR_DATA) && full;
  assign w_ovf_clr = avalonmm_write_slave_write && (avalonmm_write_slave_address == ADDR_STATUS)
                     && avalonmm_write_slave_writedata[0];

  always_ff @(posedge wrclock or negedge reset_n) begin
    if (!reset_n)                     r_ovf <= '0;
    else if (w_ovf_clr)               r_ovf <= '0;
    else if (w_drop && (r_ovf != '1)) r_ovf <= r_ovf + 1'b1;
  end

  assign w_ovf = r_ovf;
`else
  assign w_ovf = '0;
`endif

  always_comb begin
    w_status                           = '0;
    w_status[STAT_FULL]                = full;
    w_status[STAT_EMPTY]               = empty;
    w_status[STAT_OVF_LSB +: OVF_W]    = w_ovf;
    w_status[ADDR_W:0]                 = r_count;
  end

  always_ff @(posedge wrclock or negedge reset_n) begin
    if (!reset_n) avalonmm_write_slave_readdata <= '0;
    else if (avalonmm_write_slave_read)
      avalonmm_write_slave_readdata <= (avalonmm_write_slave_address == ADDR_STATUS) ? w_status : 32'h0;
  end
endmodule

// File: tb/tb_procesador_fifo_mm_to_st.sv
// Directed bench for procesador_fifo_mm_to_st; overflow expectations follow
// PROCESADOR_FIFO_OVF_CNT_EN.
module tb_procesador_fifo_mm_to_st;
  logic        wrclock = 1'b0;
  logic        reset_n;
  logic        mm_addr, mm_write, mm_read;
  logic [31:0] mm_wdata, mm_rdata;
  logic [31:0] st_data;
  logic        st_valid, st_ready;
  logic        full, empty;

  int n_tests = 0;
  int n_fail  = 0;

`ifdef PROCESADOR_FIFO_OVF_CNT_EN
  localparam logic [31:0] OVF3 = 32'h0003_0000;
`else
  localparam logic [31:0] OVF3 = 32'h0;
`endif

  procesador_fifo_mm_to_st dut (
    .wrclock                        (wrclock),
    .reset_n                        (reset_n),
    .avalonmm_write_slave_address   (mm_addr),
    .avalonmm_write_slave_write     (mm_write),
    .avalonmm_write_slave_writedata (mm_wdata),
    .avalonmm_write_slave_read      (mm_read),
    .avalonmm_write_slave_readdata  (mm_rdata),
    .avalonst_source_data           (st_data),
    .avalonst_source_valid          (st_valid),
    .avalonst_source_ready          (st_ready),
    .full                           (full),
    .empty                          (empty)
  );

  always #5 wrclock = ~wrclock;

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_tests++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
    end
  endtask

  task automatic tick();
    @(posedge wrclock);
    #1;
  endtask

  task automatic mm_wr(input logic a, input logic [31:0] d);
    mm_addr = a; mm_wdata = d; mm_write = 1'b1;
    tick();
    mm_write = 1'b0;
  endtask

  task automatic mm_rd(input logic a, output logic [31:0] d);
    mm_addr = a; mm_read = 1'b1;
    tick();
    mm_read = 1'b0;
    d = mm_rdata;
  endtask

  initial begin
    logic [31:0] rd;
    int exp_rd, gaps, seen_valid;

    reset_n = 1'b0; mm_addr = 1'b0; mm_write = 1'b0; mm_read = 1'b0;
    mm_wdata = '0; st_ready = 1'b0;
    tick(); tick();
    check("rst_valid", {31'b0, st_valid}, 32'd0);
    check("rst_data", st_data, 32'd0);
    check("rst_readdata", mm_rdata, 32'd0);
    check("rst_full_empty", {30'b0, full, empty}, 32'd1);
    reset_n = 1'b1;
    tick();
    mm_rd(1'b1, rd);
    check("status_after_reset", rd, 32'h4000_0000);

    // single word, 2-cycle latency
    st_ready = 1'b1;
    mm_wr(1'b0, 32'hA5A5_0001);
    check("lat_valid_n", {31'b0, st_valid}, 32'd0);
    check("lat_empty_n", {31'b0, empty}, 32'd0);
    tick();
    check("lat_valid_n1", {31'b0, st_valid}, 32'd1);
    check("lat_data", st_data, 32'hA5A5_0001);
    tick();
    check("lat_valid_clear", {31'b0, st_valid}, 32'd0);
    check("lat_empty_after", {31'b0, empty}, 32'd1);

    // fill to DEPTH+1 with backpressure, then drop three
    st_ready = 1'b0;
    for (int i = 0; i < 129; i++) mm_wr(1'b0, i);
    check("fill_full", {31'b0, full}, 32'd1);
    check("fill_valid", {31'b0, st_valid}, 32'd1);
    check("fill_head", st_data, 32'd0);
    for (int i = 129; i < 132; i++) mm_wr(1'b0, i);
    mm_rd(1'b1, rd);
    check("status_full_ovf", rd, 32'h8000_0080 | OVF3);
    mm_rd(1'b0, rd);
    check("read_addr0_zero", rd, 32'd0);
    mm_wr(1'b1, 32'h0000_0001);
    mm_rd(1'b1, rd);
    check("status_ovf_cleared", rd, 32'h8000_0080);
    check("hold_data", st_data, 32'd0);

    // drain
    st_ready = 1'b1;
    exp_rd = 0;
    for (int c = 0; c < 300 && exp_rd < 129; c++) begin
      if (st_valid) begin
        check("drain_data", st_data, exp_rd);
        exp_rd++;
      end
      tick();
    end
    check("drain_count", exp_rd, 32'd129);
    check("drain_valid_low", {31'b0, st_valid}, 32'd0);
    check("drain_empty", {31'b0, empty}, 32'd1);
    mm_rd(1'b1, rd);
    check("status_drained", rd, 32'h4000_0000);

    // concurrent push/pop across pointer wrap
    exp_rd = 0; gaps = 0; seen_valid = 0;
    for (int c = 0; c < 330 && exp_rd < 300; c++) begin
      if (st_valid) begin
        seen_valid = 1;
        check("stream_data", st_data, 32'h1000 + exp_rd);
        exp_rd++;
      end else if (seen_valid != 0) begin
        gaps++;
      end
      check("stream_not_full", {31'b0, full}, 32'd0);
      if (c < 300) begin
        mm_addr = 1'b0; mm_wdata = 32'h1000 + c; mm_write = 1'b1;
      end else begin
        mm_write = 1'b0;
      end
      tick();
    end
    mm_write = 1'b0;
    check("stream_count", exp_rd, 32'd300);
    check("stream_gaps", gaps, 32'd0);
    check("stream_empty", {31'b0, empty}, 32'd1);

    // reset mid-burst
    st_ready = 1'b0;
    for (int i = 0; i < 5; i++) mm_wr(1'b0, 32'hB000 + i);
    check("pre_rst_valid", {31'b0, st_valid}, 32'd1);
    check("pre_rst_data", st_data, 32'h0000_B000);
    reset_n = 1'b0;
    #1;
    check("mid_rst_valid", {31'b0, st_valid}, 32'd0);
    check("mid_rst_empty", {31'b0, empty}, 32'd1);
    check("mid_rst_data", st_data, 32'd0);
    tick();
    reset_n = 1'b1;
    tick();
    mm_rd(1'b1, rd);
    check("status_post_rst", rd, 32'h4000_0000);
    st_ready = 1'b1;
    mm_wr(1'b0, 32'hDEAD_0001);
    tick();
    check("post_rst_valid", {31'b0, st_valid}, 32'd1);
    check("post_rst_data", st_data, 32'hDEAD_0001);
    tick();
    check("post_rst_done", {31'b0, st_valid}, 32'd0);

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end
endmodule
